// File: rtl/wb_scheduler.sv
// Register-file write-back arbiter: core results vs. buffered load responses, 1-cycle registered output.
// Backpressure: core_stall when a starved or full load FIFO must drain; ld_ready drops when the FIFO is full.
module wb_scheduler #(
  parameter int MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_wb_valid,
  input  logic [4:0]  core_rd,
  input  logic [1:0]  mem_to_reg,
  input  logic [31:0] alu_out,
  input  logic [31:0] next_sel_address,
  output logic        core_stall,
  input  logic        ld_valid,
  input  logic [4:0]  ld_rd,
  input  logic [31:0] ld_data,
  output logic        ld_ready,
  output logic        rf_we,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_wdata,
  output logic [1:0]  ld_pending
);

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } ld_entry_t;

  localparam logic [3:0] AGE_MAX = 4'(MAX_WAIT);

  ld_entry_t   fifo_q [2];
  ld_entry_t   fifo_d [2];
  logic        wr_ptr_q, wr_ptr_d;
  logic        rd_ptr_q, rd_ptr_d;
  logic [1:0]  count_q, count_d;
  logic [3:0]  age_q, age_d;
  logic        rf_we_q, rf_we_d;
  logic [4:0]  rf_rd_q, rf_rd_d;
  logic [31:0] rf_wdata_q, rf_wdata_d;

  logic        core_write;
  logic [31:0] core_data;
  logic        fifo_empty;
  logic        fifo_full;
  logic        force_drain;
  logic        head_win;
  logic        core_win;
  logic        push;
  logic        pop;
  ld_entry_t   head;

  always_comb begin
    // mem_to_reg 00 and 10 are the only encodings that write in the current cycle
    core_write  = core_wb_valid & ~mem_to_reg[0] & (core_rd != 5'd0);
    core_data   = mem_to_reg[1] ? next_sel_address : alu_out;
    fifo_empty  = (count_q == 2'd0);
    fifo_full   = (count_q == 2'd2);
    ld_ready    = rst & ~fifo_full;
    force_drain = fifo_full | (~fifo_empty & (age_q == AGE_MAX));
    head_win    = force_drain | (~core_write & ~fifo_empty);
    core_win    = core_write & ~force_drain;
    core_stall  = rst & force_drain & core_write;
    pop         = head_win;
    push        = ld_valid & ld_ready & (ld_rd != 5'd0);
    head        = fifo_q[rd_ptr_q];
  end

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
    if (push) begin
      fifo_d[wr_ptr_q] = '{rd: ld_rd, data: ld_data};
    end
    // Age tracks only the entry currently visible at the head
    if (pop || fifo_empty) begin
      age_d = 4'd0;
    end else if (age_q != AGE_MAX) begin
      age_d = age_q + 4'd1;
    end else begin
      age_d = age_q;
    end
  end

  always_comb begin
    rf_we_d    = head_win | core_win;
    rf_rd_d    = rf_rd_q;
    rf_wdata_d = rf_wdata_q;
    if (head_win) begin
      rf_rd_d    = head.rd;
      rf_wdata_d = head.data;
    end else if (core_win) begin
      rf_rd_d    = core_rd;
      rf_wdata_d = core_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fifo_q     <= '{default: '0};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      age_q      <= 4'd0;
      rf_we_q    <= 1'b0;
      rf_rd_q    <= 5'd0;
      rf_wdata_q <= 32'd0;
    end else begin
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      age_q      <= age_d;
      rf_we_q    <= rf_we_d;
      rf_rd_q    <= rf_rd_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_we      = rf_we_q;
  assign rf_rd      = rf_rd_q;
  assign rf_wdata   = rf_wdata_q;
  assign ld_pending = count_q;

endmodule

// File: tb/tb_wb_scheduler.sv
// Directed scenarios plus randomized traffic against a queue-based reference model of wb_scheduler.
module tb_wb_scheduler;
  localparam int MAX_WAIT = 4;

  logic        clk;
  logic        rst;
  logic        core_wb_valid;
  logic [4:0]  core_rd;
  logic [1:0]  mem_to_reg;
  logic [31:0] alu_out;
  logic [31:0] next_sel_address;
  logic        core_stall;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        rf_we;
  logic [4:0]  rf_rd;
  logic [31:0] rf_wdata;
  logic [1:0]  ld_pending;

  int checks = 0;
  int failures = 0;

  wb_scheduler #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst), .core_wb_valid(core_wb_valid), .core_rd(core_rd),
    .mem_to_reg(mem_to_reg), .alu_out(alu_out), .next_sel_address(next_sel_address),
    .core_stall(core_stall), .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data),
    .ld_ready(ld_ready), .rf_we(rf_we), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .ld_pending(ld_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic core(input logic v, input logic [4:0] rd, input logic [1:0] m,
                      input logic [31:0] a, input logic [31:0] n);
    core_wb_valid = v; core_rd = rd; mem_to_reg = m; alu_out = a; next_sel_address = n;
  endtask

  task automatic load(input logic v, input logic [4:0] rd, input logic [31:0] d);
    ld_valid = v; ld_rd = rd; ld_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    core(1'b1, 5'd5, 2'b00, 32'h55, 32'h0);
    load(1'b1, 5'd3, 32'h77);
    #1;
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL rst_stall act=%0b exp=0", core_stall); end
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL rst_ready act=%0b exp=0", ld_ready); end
    step(); step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rst_we act=%0b exp=0", rf_we); end
    checks++; if (rf_rd !== 5'd0) begin failures++; $display("FAIL rst_rd act=%0d exp=0", rf_rd); end
    checks++; if (rf_wdata !== 32'd0) begin failures++; $display("FAIL rst_wdata act=%h exp=0", rf_wdata); end
    checks++; if (ld_pending !== 2'd0) begin failures++; $display("FAIL rst_pending act=%0d exp=0", ld_pending); end
    rst = 1'b1;
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    load(1'b0, 5'd0, 32'h0);
    step();
  endtask

  task automatic test_core_only();
    core(1'b1, 5'd5, 2'b00, 32'h1234, 32'h999);
    #1;
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL core_stall act=%0b exp=0", core_stall); end
    step();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL core_we act=%0b exp=1", rf_we); end
    checks++; if (rf_rd !== 5'd5) begin failures++; $display("FAIL core_rd act=%0d exp=5", rf_rd); end
    checks++; if (rf_wdata !== 32'h1234) begin failures++; $display("FAIL core_alu act=%h exp=1234", rf_wdata); end
    core(1'b1, 5'd6, 2'b10, 32'h5555, 32'h104);
    step();
    checks++; if (rf_rd !== 5'd6) begin failures++; $display("FAIL link_rd act=%0d exp=6", rf_rd); end
    checks++; if (rf_wdata !== 32'h104) begin failures++; $display("FAIL link_data act=%h exp=104", rf_wdata); end
    core(1'b1, 5'd0, 2'b00, 32'hFFFF, 32'h0);
    #1;
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL x0_stall act=%0b exp=0", core_stall); end
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL x0_we act=%0b exp=0", rf_we); end
    core(1'b1, 5'd8, 2'b01, 32'hAAAA, 32'h0);
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL ldissue_we act=%0b exp=0", rf_we); end
    core(1'b1, 5'd9, 2'b11, 32'hBBBB, 32'h0);
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL nowrite_we act=%0b exp=0", rf_we); end
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_load_idle();
    load(1'b1, 5'd7, 32'hDEADBEEF);
    #1;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL idle_ready act=%0b exp=1", ld_ready); end
    step();
    load(1'b0, 5'd0, 32'h0);
    checks++; if (ld_pending !== 2'd1) begin failures++; $display("FAIL idle_pend1 act=%0d exp=1", ld_pending); end
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL idle_early act=%0b exp=0", rf_we); end
    step();
    checks++; if (rf_we !== 1'b1) begin failures++; $display("FAIL idle_we act=%0b exp=1", rf_we); end
    checks++; if (rf_rd !== 5'd7) begin failures++; $display("FAIL idle_rd act=%0d exp=7", rf_rd); end
    checks++; if (rf_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL idle_data act=%h exp=deadbeef", rf_wdata); end
    checks++; if (ld_pending !== 2'd0) begin failures++; $display("FAIL idle_pend0 act=%0d exp=0", ld_pending); end
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL idle_once act=%0b exp=0", rf_we); end
  endtask

  task automatic test_starvation();
    core(1'b1, 5'd1, 2'b00, 32'h100, 32'h0);
    load(1'b1, 5'd9, 32'hA5A5A5A5);
    step();
    load(1'b0, 5'd0, 32'h0);
    checks++; if (rf_rd !== 5'd1) begin failures++; $display("FAIL starve_first act=%0d exp=1", rf_rd); end
    for (int k = 2; k <= 5; k++) begin
      core(1'b1, 5'(k), 2'b00, 32'(k * 256), 32'h0);
      #1;
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL starve_nostall k=%0d act=%0b exp=0", k, core_stall); end
      step();
      checks++; if (rf_rd !== 5'(k) || rf_we !== 1'b1) begin failures++; $display("FAIL starve_core k=%0d act=%0d exp=%0d", k, rf_rd, k); end
    end
    core(1'b1, 5'd20, 2'b10, 32'h0, 32'h2020);
    #1;
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL starve_stall act=%0b exp=1", core_stall); end
    step();
    checks++; if (rf_rd !== 5'd9 || rf_wdata !== 32'hA5A5A5A5) begin failures++; $display("FAIL starve_load act=%0d/%h exp=9/a5a5a5a5", rf_rd, rf_wdata); end
    checks++; if (ld_pending !== 2'd0) begin failures++; $display("FAIL starve_pend act=%0d exp=0", ld_pending); end
    #1;
    checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL starve_release act=%0b exp=0", core_stall); end
    step();
    checks++; if (rf_rd !== 5'd20 || rf_wdata !== 32'h2020) begin failures++; $display("FAIL starve_held act=%0d/%h exp=20/2020", rf_rd, rf_wdata); end
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    step();
  endtask

  task automatic test_full_fifo();
    core(1'b1, 5'd1, 2'b00, 32'h100, 32'h0);
    load(1'b1, 5'd10, 32'hA0);
    step();
    checks++; if (rf_rd !== 5'd1 || ld_pending !== 2'd1) begin failures++; $display("FAIL full_c1 act=%0d/%0d exp=1/1", rf_rd, ld_pending); end
    core(1'b1, 5'd2, 2'b00, 32'h200, 32'h0);
    load(1'b1, 5'd11, 32'hB0);
    step();
    checks++; if (rf_rd !== 5'd2 || ld_pending !== 2'd2) begin failures++; $display("FAIL full_c2 act=%0d/%0d exp=2/2", rf_rd, ld_pending); end
    core(1'b1, 5'd3, 2'b00, 32'h300, 32'h0);
    load(1'b1, 5'd12, 32'hC0);
    #1;
    checks++; if (ld_ready !== 1'b0) begin failures++; $display("FAIL full_ready act=%0b exp=0", ld_ready); end
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL full_stall act=%0b exp=1", core_stall); end
    step();
    checks++; if (rf_rd !== 5'd10 || rf_wdata !== 32'hA0) begin failures++; $display("FAIL full_l1 act=%0d/%h exp=10/a0", rf_rd, rf_wdata); end
    #1;
    checks++; if (ld_ready !== 1'b1 || core_stall !== 1'b0) begin failures++; $display("FAIL full_reopen act=%0b/%0b exp=1/0", ld_ready, core_stall); end
    step();
    checks++; if (rf_rd !== 5'd3 || ld_pending !== 2'd2) begin failures++; $display("FAIL full_c3 act=%0d/%0d exp=3/2", rf_rd, ld_pending); end
    core(1'b1, 5'd4, 2'b00, 32'h400, 32'h0);
    load(1'b0, 5'd0, 32'h0);
    #1;
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL full_stall2 act=%0b exp=1", core_stall); end
    step();
    checks++; if (rf_rd !== 5'd11 || rf_wdata !== 32'hB0) begin failures++; $display("FAIL full_l2 act=%0d/%h exp=11/b0", rf_rd, rf_wdata); end
    step();
    checks++; if (rf_rd !== 5'd4 || rf_wdata !== 32'h400) begin failures++; $display("FAIL full_c4 act=%0d/%h exp=4/400", rf_rd, rf_wdata); end
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    step();
    checks++; if (rf_rd !== 5'd12 || rf_wdata !== 32'hC0 || ld_pending !== 2'd0) begin failures++; $display("FAIL full_l3 act=%0d/%h/%0d exp=12/c0/0", rf_rd, rf_wdata, ld_pending); end
  endtask

  task automatic test_push_pop();
    load(1'b1, 5'd13, 32'hD1);
    step();
    checks++; if (ld_pending !== 2'd1) begin failures++; $display("FAIL pp_fill act=%0d exp=1", ld_pending); end
    load(1'b1, 5'd14, 32'hD2);
    step();
    checks++; if (rf_rd !== 5'd13 || rf_we !== 1'b1 || ld_pending !== 2'd1) begin failures++; $display("FAIL pp_swap act=%0d/%0d exp=13/1", rf_rd, ld_pending); end
    core(1'b1, 5'd1, 2'b00, 32'h1, 32'h0);
    load(1'b1, 5'd0, 32'hBAD);
    #1;
    checks++; if (ld_ready !== 1'b1) begin failures++; $display("FAIL pp_x0_ready act=%0b exp=1", ld_ready); end
    step();
    load(1'b0, 5'd0, 32'h0);
    checks++; if (rf_rd !== 5'd1 || ld_pending !== 2'd1) begin failures++; $display("FAIL pp_x0_drop act=%0d/%0d exp=1/1", rf_rd, ld_pending); end
    for (int k = 2; k <= 4; k++) begin
      core(1'b1, 5'(k), 2'b00, 32'(k), 32'h0);
      #1;
      checks++; if (core_stall !== 1'b0) begin failures++; $display("FAIL pp_age k=%0d act=%0b exp=0", k, core_stall); end
      step();
    end
    core(1'b1, 5'd21, 2'b00, 32'h21, 32'h0);
    #1;
    checks++; if (core_stall !== 1'b1) begin failures++; $display("FAIL pp_force act=%0b exp=1", core_stall); end
    step();
    checks++; if (rf_rd !== 5'd14 || rf_wdata !== 32'hD2) begin failures++; $display("FAIL pp_head act=%0d/%h exp=14/d2", rf_rd, rf_wdata); end
    step();
    checks++; if (rf_rd !== 5'd21) begin failures++; $display("FAIL pp_held act=%0d exp=21", rf_rd); end
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    step();
    checks++; if (rf_we !== 1'b0 || ld_pending !== 2'd0) begin failures++; $display("FAIL pp_end act=%0b/%0d exp=0/0", rf_we, ld_pending); end
  endtask

  task automatic test_reset_mid();
    core(1'b1, 5'd1, 2'b00, 32'h11, 32'h0);
    load(1'b1, 5'd2, 32'h22);
    step();
    core(1'b1, 5'd3, 2'b00, 32'h33, 32'h0);
    load(1'b1, 5'd4, 32'h44);
    step();
    checks++; if (ld_pending !== 2'd2) begin failures++; $display("FAIL rm_fill act=%0d exp=2", ld_pending); end
    core(1'b1, 5'd5, 2'b00, 32'h55, 32'h0);
    load(1'b0, 5'd0, 32'h0);
    rst = 1'b0;
    #1;
    checks++; if (core_stall !== 1'b0 || ld_ready !== 1'b0) begin failures++; $display("FAIL rm_comb act=%0b/%0b exp=0/0", core_stall, ld_ready); end
    step();
    checks++; if (rf_we !== 1'b0 || ld_pending !== 2'd0) begin failures++; $display("FAIL rm_cancel act=%0b/%0d exp=0/0", rf_we, ld_pending); end
    rst = 1'b1;
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    step();
    checks++; if (rf_we !== 1'b0 || ld_pending !== 2'd0) begin failures++; $display("FAIL rm_stale1 act=%0b/%0d exp=0/0", rf_we, ld_pending); end
    step();
    checks++; if (rf_we !== 1'b0) begin failures++; $display("FAIL rm_stale2 act=%0b exp=0", rf_we); end
  endtask

  task automatic test_random();
    logic [36:0] mq[$];
    int          cyc;
    int          head_start;
    int          cnt;
    bit          fd, cw, rdy, popped;
    bit          exp_we, exp_stall, hold_ld;
    logic [4:0]  exp_rd;
    logic [31:0] exp_wd;
    cyc = 0; head_start = 0;
    exp_we = 0; exp_stall = 0; hold_ld = 0; exp_rd = 0; exp_wd = 0;
    for (int i = 0; i < 3000; i++) begin
      checks++; if (rf_we !== exp_we) begin failures++; $display("FAIL rnd_we cyc=%0d act=%0b exp=%0b", cyc, rf_we, exp_we); end
      if (exp_we) begin
        checks++; if (rf_rd !== exp_rd || rf_wdata !== exp_wd) begin failures++; $display("FAIL rnd_data cyc=%0d act=%0d/%h exp=%0d/%h", cyc, rf_rd, rf_wdata, exp_rd, exp_wd); end
      end
      checks++; if (ld_pending !== 2'(mq.size())) begin failures++; $display("FAIL rnd_pend cyc=%0d act=%0d exp=%0d", cyc, ld_pending, mq.size()); end
      if (!exp_stall) begin
        core($urandom_range(0, 9) < 7, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)),
             2'($urandom_range(0, 3)), $urandom, $urandom);
      end
      if (!hold_ld) begin
        load($urandom_range(0, 9) < 4, ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31)), $urandom);
      end
      #1;
      cnt = mq.size();
      rdy = (cnt < 2);
      fd = (cnt == 2) || (cnt > 0 && (cyc - head_start) >= MAX_WAIT);
      cw = core_wb_valid && (mem_to_reg == 2'b00 || mem_to_reg == 2'b10) && core_rd != 5'd0;
      exp_stall = fd && cw;
      checks++; if (core_stall !== exp_stall) begin failures++; $display("FAIL rnd_stall cyc=%0d act=%0b exp=%0b", cyc, core_stall, exp_stall); end
      checks++; if (ld_ready !== rdy) begin failures++; $display("FAIL rnd_ready cyc=%0d act=%0b exp=%0b", cyc, ld_ready, rdy); end
      exp_we = 0; popped = 0;
      if (cnt > 0 && (fd || !cw)) begin
        exp_we = 1; popped = 1;
        {exp_rd, exp_wd} = mq.pop_front();
      end else if (cw) begin
        exp_we = 1;
        exp_rd = core_rd;
        exp_wd = (mem_to_reg == 2'b10) ? next_sel_address : alu_out;
      end
      if (ld_valid && rdy && ld_rd != 5'd0) mq.push_back({ld_rd, ld_data});
      hold_ld = ld_valid && !rdy;
      if (popped || cnt == 0) head_start = cyc + 1;
      cyc++;
      step();
    end
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    load(1'b0, 5'd0, 32'h0);
  endtask

  initial begin
    rst = 1'b0;
    core(1'b0, 5'd0, 2'b11, 32'h0, 32'h0);
    load(1'b0, 5'd0, 32'h0);
    step();
    test_reset();
    test_core_only();
    test_load_idle();
    test_starvation();
    test_full_fifo();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_scheduler.md
# wb_scheduler

Write-back scheduler for the RV32I core's single register-file write port. It merges the core's same-cycle write-back results (ALU result or link address) with load data that returns from data memory with variable latency. Load responses are buffered in a 2-entry FIFO. A bounded-wait policy keeps loads from being starved. The block sits between the execute/memory stage and the register file, and replaces the direct write-back mux drive of the register file.

## Interface
Parameters:
- MAX_WAIT, 4: cycles a buffered load may wait at the FIFO head before the core is forced to stall; legal 1..15.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-low reset.
- core_wb_valid  in  1  core presents a write-back this cycle.
- core_rd  in  5  core destination register.
- mem_to_reg  in  2  write-back source: 00 = alu_out, 10 = next_sel_address, 01 = load issued (data arrives on the ld_* channel, no write now), 11 = no write.
- alu_out  in  32  ALU result.
- next_sel_address  in  32  PC+4 link value.
- core_stall  out  1  core must hold all core_* inputs; the current core write-back is not accepted this cycle.
- ld_valid  in  1  load response valid.
- ld_rd  in  5  load destination register.
- ld_data  in  32  load data, already sign/zero-extended.
- ld_ready  out  1  scheduler accepts a load response this cycle.
- rf_we  out  1  register-file write enable, registered.
- rf_rd  out  5  register-file write address, registered.
- rf_wdata  out  32  register-file write data, registered.
- ld_pending  out  2  current FIFO occupancy (0..2).

## Operation
- A core request is a *write* when core_wb_valid=1, mem_to_reg is 00 or 10, and core_rd≠0.
  - With core_rd=0, or mem_to_reg 01/11, the request is consumed with no write and never stalls.
- Load handshake: a transfer occurs when ld_valid & ld_ready.
  - A load with ld_rd=0 is accepted and discarded; it is not pushed.
  - Any other accepted load is pushed as {rd, data}.
- ld_ready = rst & (count<2). It depends on no other input.
- force_drain = (count==2) | (count≠0 & age==MAX_WAIT).
- Per-cycle winner selection, in priority order:
  1. force_drain: FIFO head wins. core_stall = core write pending.
  2. Else, if a core write is pending: core wins.
  3. Else, if the FIFO is non-empty: the head wins.
  4. Else: no write.
- core_stall is combinational and is asserted only in case 1 with a core write pending. A non-writing core request is never stalled.
- FIFO pop and push may occur in the same cycle. Occupancy is unchanged and order is preserved.
  - A push into an empty FIFO is not eligible to win in that same cycle. The head becomes visible next cycle.
- Age counter:
  - Reset to 0 on pop or while the FIFO is empty.
  - Otherwise increments each cycle the head is present and not popped.
  - Saturates at MAX_WAIT.
  - After a pop with a remaining entry, age restarts at 0 for the new head.
- WAW ordering between the core and loads to the same rd is resolved upstream (scoreboard). This block writes in grant order.

## Timing
- Reset (rst=0 at a clock edge): rf_we=0, rf_rd=0, rf_wdata=0, FIFO emptied, age=0.
  - ld_pending reads 0 after the edge.
  - ld_ready=0 and core_stall=0 while rst=0.
- Reset asserted mid-operation discards buffered loads, and the write registered in that cycle is cancelled.
- Latency: the winner chosen in cycle N appears on rf_we/rf_rd/rf_wdata after edge N, i.e. during cycle N+1. rf_we is high for exactly one cycle per granted write.
- Loads: minimum latency is 2 cycles (push at edge N, earliest grant in N+1, rf_we in N+2).
- Worst-case head wait is MAX_WAIT cycles plus 1 grant cycle.
- Throughput: one register-file write per cycle. No bubbles when both sources are ready.

## Test plan
- Core-only traffic, rf write data: core_rd=5, mem_to_reg=00, alu_out=0x1234 for one cycle.
  - rf_we=1, rf_rd=5, rf_wdata=0x1234 the next cycle.
  - mem_to_reg=10 with next_sel_address=0x104 writes 0x104.
  - core_rd=0 gives rf_we=0.
- Idle-core load path: ld_rd=7, ld_data=0xDEADBEEF with the core idle.
  - ld_pending=1 after the push edge.
  - rf_we=1, rf_rd=7 two cycles after the push; ld_pending returns to 0.
- Starvation bound (MAX_WAIT=4): one load buffered with continuous core writes.
  - Core wins for 4 cycles.
  - Cycle 5: core_stall=1 and the load is written.
  - Stalled core write is written the following cycle with its values intact.
- Full FIFO: two loads pushed back-to-back under continuous core writes.
  - ld_ready=0 at count 2, with force_drain and core_stall asserted.
  - A third ld_valid is held until ld_ready=1.
  - Loads retire in push order.
- Simultaneous push and pop at count 1.
  - Count stays 1 and the head retires.
  - The new entry's age starts at 0.
  - An ld_rd=0 response is accepted and never written.
- Reset mid-operation: rst=0 with 2 entries buffered and a grant pending.
  - rf_we=0 next cycle and ld_pending=0.
  - No stale write appears after rst returns to 1.
